// File: rtl/insn_queue.sv
// Instruction queue between the prefetch stage and decode: steers fetch address/enable,
// buffers returned words in a small FIFO. Optional macro: IQ_HALT_ON_ERR_EN (halt fetch after a bus error).
module insn_queue #(
  parameter int unsigned     AW            = 32,
  parameter int unsigned     LGDEPTH       = 2,
  parameter logic [AW-1:0]   RESET_ADDRESS = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic [AW-1:0] i_new_pc,
  output logic          o_fetch_ce,
  output logic [AW-1:0] o_fetch_pc,
  output logic          o_stalled_n,
  input  logic          i_valid,
  input  logic [31:0]   i_insn,
  input  logic [AW-1:0] i_insn_pc,
  input  logic          i_illegal,
  output logic          o_valid,
  output logic [31:0]   o_insn,
  output logic [AW-1:0] o_pc,
  output logic          o_illegal,
  input  logic          i_ready
);

  localparam int unsigned      DEPTH      = 2 ** LGDEPTH;
  localparam int unsigned      EW         = 32 + AW + 1;
  localparam logic [LGDEPTH:0] FULL_COUNT = (LGDEPTH + 1)'(DEPTH);

  logic [EW-1:0]      mem [DEPTH];
  logic [LGDEPTH-1:0] rd_ptr, wr_ptr;
  logic [LGDEPTH:0]   count;
  logic [AW-1:0]      r_fetch_pc;
  logic               r_halted;

  logic full, match, pop, push, drop;

  always_comb begin
    full  = (count == FULL_COUNT);
    match = i_valid && (i_insn_pc == r_fetch_pc) && !i_clear;
    pop   = o_valid && i_ready;
    // A full queue can still take the word when the head leaves in the same cycle
    push  = match && (!full || pop);
    drop  = i_valid && !match;
  end

  assign o_stalled_n = push || drop || !i_valid;
  assign o_fetch_ce  = !i_valid && !r_halted && !full && !i_clear;
  assign o_fetch_pc  = r_fetch_pc;
  assign o_valid     = (count != '0);
  assign {o_insn, o_pc, o_illegal} = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= {i_insn, i_insn_pc, i_illegal};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      r_fetch_pc <= RESET_ADDRESS;
    end else if (i_clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      r_fetch_pc <= i_new_pc;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        r_fetch_pc <= r_fetch_pc + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef IQ_HALT_ON_ERR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear)
      r_halted <= 1'b0;
    else if (push && i_illegal)
      r_halted <= 1'b1;
  end
`else
  always_comb r_halted = 1'b0;
`endif

endmodule
